// File: rtl/pipelined_adder_sub.sv
// WIDTH-bit add/subtract with the ripple carry cut into STAGES registered
// segments. Each segment adds its slice of the operands plus the carry
// registered by the segment below, so the carry advances one segment per clock.
// Signed overflow detection, optional saturation and a valid/ready stream
// handshake with a single global advance enable.
module pipelined_adder_sub #(
  parameter int WIDTH    = 16,
  parameter int STAGES   = 4,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int SEG = WIDTH / STAGES;

  // Stage inputs (st_*) and stage results (nx_*); index k is segment k.
  logic [WIDTH-1:0] st_a [STAGES];
  logic [WIDTH-1:0] st_b [STAGES];
  logic [WIDTH-1:0] st_s [STAGES];
  logic             st_c [STAGES];
  logic             st_v [STAGES];
  logic [WIDTH-1:0] nx_s [STAGES];
  logic             nx_c [STAGES];

  // Registers at the output of each segment. The last entry of r_v is the
  // stream's out_valid; the final sum/flags live in the output registers.
  logic [WIDTH-1:0] r_a  [STAGES];
  logic [WIDTH-1:0] r_b  [STAGES];
  logic [WIDTH-1:0] r_s  [STAGES];
  logic             r_c  [STAGES];
  logic             r_v  [STAGES];

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic [SEG:0]     seg;
  logic [WIDTH-1:0] raw;
  logic             a_msb;
  logic             b_msb;
  logic             ovf;
  logic [WIDTH-1:0] res;

  // Whole pipeline advances together whenever the output slot is free or drained.
  assign en        = ~out_valid | out_ready;
  assign in_ready  = en;
  assign out_valid = r_v[STAGES-1];

  // Operand conditioning, per-segment ripple add, and final overflow/saturation.
  always_comb begin
    b_eff = sub ? ~b : b;
    c0    = sub ? ~cin : cin;

    st_a[0] = a;
    st_b[0] = b_eff;
    st_s[0] = '0;
    st_c[0] = c0;
    st_v[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      st_a[k] = r_a[k-1];
      st_b[k] = r_b[k-1];
      st_s[k] = r_s[k-1];
      st_c[k] = r_c[k-1];
      st_v[k] = r_v[k-1];
    end

    seg = '0;
    for (int k = 0; k < STAGES; k++) begin
      seg = {1'b0, st_a[k][k*SEG +: SEG]} + {1'b0, st_b[k][k*SEG +: SEG]}
          + {{SEG{1'b0}}, st_c[k]};
      nx_s[k] = st_s[k];
      nx_s[k][k*SEG +: SEG] = seg[SEG-1:0];
      nx_c[k] = seg[SEG];
    end

    raw   = nx_s[STAGES-1];
    a_msb = st_a[STAGES-1][WIDTH-1];
    b_msb = st_b[STAGES-1][WIDTH-1];
    ovf   = (a_msb == b_msb) & (raw[WIDTH-1] != a_msb);
    res   = raw;
    if ((SATURATE != 0) && ovf) begin
      res = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  // Segment registers advance on en; output registers load only on a valid result.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_v[k] <= 1'b0;
      end
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (en) begin
      for (int k = 0; k < STAGES; k++) begin
        r_v[k] <= st_v[k];
        r_a[k] <= st_a[k];
        r_b[k] <= st_b[k];
        r_s[k] <= nx_s[k];
        r_c[k] <= nx_c[k];
      end
      if (st_v[STAGES-1]) begin
        sum       <= res;
        carry_out <= nx_c[STAGES-1];
        overflow  <= ovf;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_adder_sub.sv
// Directed bench: one wrapping and one saturating instance share the stimulus.
module tb_pipelined_adder_sub;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         cin;
  logic         out_ready;

  logic         in_ready_w, out_valid_w, carry_w, ovf_w;
  logic [W-1:0] sum_w;
  logic         in_ready_s, out_valid_s, carry_s, ovf_s;
  logic [W-1:0] sum_s;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipelined_adder_sub #(.WIDTH(W), .STAGES(4), .SATURATE(0)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
    .a(a), .b(b), .sub(sub), .cin(cin),
    .out_valid(out_valid_w), .out_ready(out_ready),
    .sum(sum_w), .carry_out(carry_w), .overflow(ovf_w)
  );

  pipelined_adder_sub #(.WIDTH(W), .STAGES(4), .SATURATE(1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .a(a), .b(b), .sub(sub), .cin(cin),
    .out_valid(out_valid_s), .out_ready(out_ready),
    .sum(sum_s), .carry_out(carry_s), .overflow(ovf_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op, verify exact 4-cycle latency and the results of both instances.
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic ts, input logic tc,
                        input logic [W-1:0] exp_w, input logic [W-1:0] exp_s,
                        input logic exp_co, input logic exp_ov);
    a = ta; b = tb_; sub = ts; cin = tc; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk({tag, "_in_ready"}, in_ready_w, 1);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk({tag, "_early_valid"}, out_valid_w, 0);
    tick();
    chk({tag, "_valid_w"}, out_valid_w, 1);
    chk({tag, "_valid_s"}, out_valid_s, 1);
    chk({tag, "_sum_w"}, sum_w, exp_w);
    chk({tag, "_sum_s"}, sum_s, exp_s);
    chk({tag, "_co_w"}, carry_w, exp_co);
    chk({tag, "_ov_w"}, ovf_w, exp_ov);
    chk({tag, "_ov_s"}, ovf_s, exp_ov);
  endtask

  int issued;
  int rcv;
  int stall_left;
  int stall_seen;
  int cyc;

  initial begin
    rst = 1'b1; in_valid = 1'b1; a = 16'h1234; b = 16'h4321;
    sub = 1'b0; cin = 1'b0; out_ready = 1'b1;

    // Reset held two cycles with in_valid asserted.
    tick();
    tick();
    chk("rst_out_valid", out_valid_w, 0);
    chk("rst_sum", sum_w, 16'h0000);
    chk("rst_ovf", ovf_w, 0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst_in_ready", in_ready_w, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_no_output", out_valid_w, 0);
    end

    // Directed arithmetic vectors.
    run_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    run_op("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 16'h7FFF, 1'b0, 1'b1);
    run_op("sub_ovf",  16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 16'h8000, 1'b1, 1'b1);
    run_op("sub_neg",  16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_brw",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 16'hFFFD, 1'b0, 1'b0);
    run_op("add_negovf", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 16'h8000, 1'b1, 1'b1);
    run_op("add_cin",  16'h00FF, 16'h0F00, 1'b0, 1'b1, 16'h1000, 16'h1000, 1'b0, 1'b0);
    tick();
    chk("idle_after_ops", out_valid_w, 0);

    // Back-pressure stream: a=i, b=0x0100, 3-cycle stall after the first result.
    issued = 0; rcv = 0; stall_left = 0; stall_seen = 0; cyc = 0;
    sub = 1'b0; cin = 1'b0; b = 16'h0100;
    while (rcv < 8 && cyc < 60) begin
      out_ready = (stall_left == 0);
      in_valid  = (issued < 8);
      a         = W'(issued);
      #1;
      if (out_valid_w && !out_ready) begin
        chk("bp_in_ready_stall", in_ready_w, 0);
        chk("bp_sum_held", sum_w, 16'h0100 + W'(rcv));
        stall_seen++;
      end else begin
        chk("bp_in_ready", in_ready_w, 1);
      end
      if (out_valid_w && out_ready) begin
        chk("bp_sum_w", sum_w, 16'h0100 + W'(rcv));
        chk("bp_sum_s", sum_s, 16'h0100 + W'(rcv));
        rcv++;
        if (rcv == 1) stall_left = 3;
      end else if (!out_ready) begin
        stall_left--;
      end
      if (in_valid && in_ready_w) issued++;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_received", rcv, 8);
    chk("bp_stall_cycles", stall_seen, 3);
    tick();
    chk("bp_no_duplicate", out_valid_w, 0);

    // Reset with three ops in flight.
    b = 16'h0001;
    for (int i = 0; i < 3; i++) begin
      a = 16'h0010 + W'(i); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("midrst_no_output", out_valid_w, 0);
      tick();
    end
    run_op("post_rst", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 16'h2345, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
